// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: synchronises the raw pins, deframes 11-bit
// frames, strips E0/F0 prefixes and emits make/break/error strobes.
module ps2_receiver #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       extended,
    output logic       key_pressed,
    output logic       key_released,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic       clk_s1_q, clk_s2_q, clk_hist_q;
    logic       dat_s1_q, dat_s2_q;
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [7:0] scan_q, scan_d;
    logic       extended_q, extended_d;
    logic       kp_q, kp_d;
    logic       kr_q, kr_d;
    logic       fe_q, fe_d;

    logic fall;
    logic din;

    assign fall = clk_hist_q & ~clk_s2_q;
    assign din  = dat_s2_q;

    // Pin synchronisers idle high so reset never looks like a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_hist_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_hist_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            tmo_cnt_q  <= 32'd0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            scan_q     <= 8'h00;
            extended_q <= 1'b0;
            kp_q       <= 1'b0;
            kr_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tmo_cnt_q  <= tmo_cnt_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            scan_q     <= scan_d;
            extended_q <= extended_d;
            kp_q       <= kp_d;
            kr_q       <= kr_d;
            fe_q       <= fe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tmo_cnt_d  = tmo_cnt_q + 32'd1;
        ext_d      = ext_q;
        brk_d      = brk_q;
        scan_d     = scan_q;
        extended_d = extended_q;
        kp_d       = 1'b0;
        kr_d       = 1'b0;
        fe_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_cnt_d = 32'd0;
                if (fall && !din) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    parity_d = din;
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_d = S_IDLE;
                    if (din && ((^shift_q) ^ parity_q)) begin
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            if (!brk_q) begin
                                scan_d     = shift_q;
                                extended_d = ext_q;
                                kp_d       = 1'b1;
                            end else begin
                                kr_d = 1'b1;
                            end
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end
                    end else begin
                        fe_d  = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A falling edge always wins over an expiring timeout.
        if (fall) begin
            tmo_cnt_d = 32'd0;
        end else if (state_q != S_IDLE && tmo_cnt_q == TMO_LAST) begin
            state_d   = S_IDLE;
            tmo_cnt_d = 32'd0;
            fe_d      = 1'b1;
            ext_d     = 1'b0;
            brk_d     = 1'b0;
        end
    end

    assign scan_code    = scan_q;
    assign extended     = extended_q;
    assign key_pressed  = kp_q;
    assign key_released = kr_q;
    assign frame_err    = fe_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: drives PS/2 frames bit by bit and checks
// decoded codes, strobe counts and the exact timeout latency.
module tb_ps2_receiver;

    localparam int TMO = 100;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       extended;
    logic       key_pressed;
    logic       key_released;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int kp_cnt = 0;
    int kr_cnt = 0;
    int fe_cnt = 0;
    int excl_viol = 0;
    int kp0, kr0, fe0;

    ps2_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .scan_code    (scan_code),
        .extended     (extended),
        .key_pressed  (key_pressed),
        .key_released (key_released),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (key_pressed)  kp_cnt++;
            if (key_released) kr_cnt++;
            if (frame_err)    fe_cnt++;
            if (int'(key_pressed) + int'(key_released) + int'(frame_err) > 1) excl_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        kp0 = kp_cnt;
        kr0 = kr_cnt;
        fe0 = fe_cnt;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (4) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (8) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par_ok ? ~^d : ^d);
        send_bit(stop_ok);
        ps2_data = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_scan", 32'(scan_code), 32'h00);
        check("rst_ext", 32'(extended), 32'h0);
        check("rst_strobes", {29'd0, key_pressed, key_released, frame_err}, 32'h0);
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // Extended make
        mark();
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
        check("emk_kp", 32'(kp_cnt - kp0), 32'd1);
        check("emk_other", 32'((kr_cnt - kr0) + (fe_cnt - fe0)), 32'd0);
        check("emk_scan", 32'(scan_code), 32'h75);
        check("emk_ext", 32'(extended), 32'h1);

        // Extended break, then plain make
        mark();
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
        check("ebrk_kr", 32'(kr_cnt - kr0), 32'd1);
        check("ebrk_kp", 32'(kp_cnt - kp0), 32'd0);
        check("ebrk_scan", 32'(scan_code), 32'h75);
        check("ebrk_ext", 32'(extended), 32'h1);
        mark();
        send_frame(8'h6B, 1'b1, 1'b1);
        check("mk6b_kp", 32'(kp_cnt - kp0), 32'd1);
        check("mk6b_scan", 32'(scan_code), 32'h6B);
        check("mk6b_ext", 32'(extended), 32'h0);

        // Parity error then recovery
        mark();
        send_frame(8'h1C, 1'b0, 1'b1);
        check("par_fe", 32'(fe_cnt - fe0), 32'd1);
        check("par_kp", 32'(kp_cnt - kp0), 32'd0);
        check("par_scan", 32'(scan_code), 32'h6B);
        mark();
        send_frame(8'h1C, 1'b1, 1'b1);
        check("par_ok_kp", 32'(kp_cnt - kp0), 32'd1);
        check("par_ok_scan", 32'(scan_code), 32'h1C);

        // Timeout: start + 4 data bits, last fall hand-timed
        mark();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        #1 ps2_clk = 1'b0;
        // Low seen at edge 1, fall acted on at edge 3, error flop set at edge 3+TMO
        for (int k = 1; k <= TMO + 5; k++) begin
            @(posedge clk);
            if (k == 8) #1 ps2_clk = 1'b1;
            @(negedge clk);
            if (k == TMO + 2) check("tmo_early", 32'(frame_err), 32'h0);
            if (k == TMO + 3) check("tmo_exact", 32'(frame_err), 32'h1);
            if (k == TMO + 4) check("tmo_after", 32'(frame_err), 32'h0);
        end
        check("tmo_fe_cnt", 32'(fe_cnt - fe0), 32'd1);
        mark();
        send_frame(8'h72, 1'b1, 1'b1);
        check("tmo_next_kp", 32'(kp_cnt - kp0), 32'd1);
        check("tmo_next_scan", 32'(scan_code), 32'h72);

        // Stray edges in IDLE, break prefix cleared by a bad stop bit
        mark();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        repeat (10) @(posedge clk);
        check("stray_none", 32'((kp_cnt - kp0) + (kr_cnt - kr0) + (fe_cnt - fe0)), 32'd0);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h29, 1'b1, 1'b0);
        check("stop_fe", 32'(fe_cnt - fe0), 32'd1);
        send_frame(8'h74, 1'b1, 1'b1);
        check("clr_kp", 32'(kp_cnt - kp0), 32'd1);
        check("clr_kr", 32'(kr_cnt - kr0), 32'd0);
        check("clr_scan", 32'(scan_code), 32'h74);

        // Reset in the middle of a frame
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("mrst_scan", 32'(scan_code), 32'h00);
        check("mrst_outs", {28'd0, extended, key_pressed, key_released, frame_err}, 32'h0);
        repeat (3) @(posedge clk);
        ps2_data = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        mark();
        send_frame(8'h75, 1'b1, 1'b1);
        check("mrst_kp", 32'(kp_cnt - kp0), 32'd1);
        check("mrst_scan2", 32'(scan_code), 32'h75);
        check("mrst_fe", 32'(fe_cnt - fe0), 32'd0);

        check("exclusive", 32'(excl_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
